// File: rtl/sprite_addr_gen.sv
// Sprite walker: emits frame-buffer addresses and sprite ROM indices for an SPR_W x SPR_H sprite.
// Optional mirrored placement is enabled with the SPRITE_ADDR_FLIP_EN macro.
module sprite_addr_gen #(
  parameter int ADDR_W = 19,
  parameter int STRIDE = 640,
  parameter int SPR_W = 8,
  parameter int SPR_H = 8,
  localparam int PIX_W = ((SPR_W * SPR_H) > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef SPRITE_ADDR_FLIP_EN
  input  logic              flip_x,
  input  logic              flip_y,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  pix_idx,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  row_base;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [PIX_W-1:0]   pix;
  logic [ADDR_W-1:0]  col_term;
  logic               last_pix;
  logic               take;

  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
  assign take     = (state == RUN) && addr_ready;

`ifdef SPRITE_ADDR_FLIP_EN
  localparam logic [ADDR_W-1:0] ROW_SPAN = ADDR_W'((SPR_H - 1) * STRIDE);

  logic fx;
  logic fy;

  // Flip flags are captured alongside the base so a walk is mirrored consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fx <= 1'b0;
      fy <= 1'b0;
    end else if ((state == IDLE) && start) begin
      fx <= flip_x;
      fy <= flip_y;
    end
  end

  assign col_term = fx ? ADDR_W'(COL_LAST - col) : ADDR_W'(col);
`else
  assign col_term = ADDR_W'(col);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // row_base tracks base + row*STRIDE incrementally, so no multiplier is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
      col      <= '0;
      row      <= '0;
      pix      <= '0;
    end else if ((state == IDLE) && start) begin
`ifdef SPRITE_ADDR_FLIP_EN
      row_base <= flip_y ? (base_addr + ROW_SPAN) : base_addr;
`else
      row_base <= base_addr;
`endif
      col      <= '0;
      row      <= '0;
      pix      <= '0;
    end else if (take) begin
      pix <= pix + PIX_W'(1);
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + ROW_W'(1);
`ifdef SPRITE_ADDR_FLIP_EN
        row_base <= fy ? (row_base - STEP) : (row_base + STEP);
`else
        row_base <= row_base + STEP;
`endif
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    addr       = '0;
    pix_idx    = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        addr       = row_base + col_term;
        pix_idx    = pix;
        if (addr_ready && last_pix) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
